// File: rtl/encode_opnd_bytes_pkg.sv
// Shared types and constants for the serialising x86 instruction encoder.
// FSM state encoding, instruction length bound and the OPND_ENC_* operand form codes.
package encode_opnd_bytes_pkg;

  localparam int unsigned MAX_INSTR_LEN = 12;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StOpc   = 3'd1,
    StModrm = 3'd2,
    StSib   = 3'd3,
    StDisp  = 3'd4,
    StImm   = 3'd5
  } state_e;

  localparam logic [3:0] OPND_ENC_NONE                = 4'd0;
  localparam logic [3:0] OPND_ENC_IMM                 = 4'd1;
  localparam logic [3:0] OPND_ENC_DISP8               = 4'd2;
  localparam logic [3:0] OPND_ENC_DISP32              = 4'd3;
  localparam logic [3:0] OPND_ENC_REG_IMM             = 4'd4;
  localparam logic [3:0] OPND_ENC_EAX_IMM             = 4'd5;
  localparam logic [3:0] OPND_ENC_MODREGRM_RM         = 4'd6;
  localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG     = 4'd7;
  localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM     = 4'd8;
  localparam logic [3:0] OPND_ENC_MODREGRM_RM_IMM     = 4'd9;
  localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM_IMM = 4'd10;
  localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG_IMM = 4'd11;

  function automatic logic form_has_modrm(input logic [3:0] form);
    return form inside {OPND_ENC_MODREGRM_RM, OPND_ENC_MODREGRM_RM_REG,
                        OPND_ENC_MODREGRM_REG_RM, OPND_ENC_MODREGRM_RM_IMM,
                        OPND_ENC_MODREGRM_REG_RM_IMM, OPND_ENC_MODREGRM_RM_REG_IMM};
  endfunction

  function automatic logic form_has_imm(input logic [3:0] form);
    return form inside {OPND_ENC_IMM, OPND_ENC_MODREGRM_RM_IMM, OPND_ENC_REG_IMM,
                        OPND_ENC_EAX_IMM, OPND_ENC_MODREGRM_REG_RM_IMM,
                        OPND_ENC_MODREGRM_RM_REG_IMM};
  endfunction

endpackage

// File: rtl/encode_opnd_len.sv
// Combinational presence/length decode for the optional ModR/M, SIB, displacement
// and immediate fields of one instruction.
module encode_opnd_len
  import encode_opnd_bytes_pkg::*;
(
  input  logic [3:0] i_opnd_form,
  input  logic [7:0] i_modrm,
  input  logic [2:0] i_imm_len,
  input  logic       i_addr16,
  output logic       o_has_modrm,
  output logic       o_has_sib,
  output logic [2:0] o_disp_len,
  output logic [2:0] o_imm_bytes
);

  logic [1:0] w_mod;
  logic [2:0] w_rm;
  logic       w_mem;

  assign w_mod = i_modrm[7:6];
  assign w_rm  = i_modrm[2:0];
  assign w_mem = o_has_modrm && (w_mod != 2'b11);

  assign o_has_modrm = form_has_modrm(i_opnd_form);
  assign o_has_sib   = w_mem && !i_addr16 && (w_rm == 3'b100);

  always_comb begin
    o_disp_len = 3'd0;
    if (i_opnd_form == OPND_ENC_DISP8) begin
      o_disp_len = 3'd1;
    end else if (i_opnd_form == OPND_ENC_DISP32) begin
      o_disp_len = 3'd4;
    end else if (w_mem) begin
      if (w_mod == 2'b01) begin
        o_disp_len = 3'd1;
      end else if (w_mod == 2'b10) begin
        o_disp_len = i_addr16 ? 3'd2 : 3'd4;
      end else if (w_rm == 3'b101 && !i_addr16) begin
        o_disp_len = 3'd4;
      end else if (w_rm == 3'b110 && i_addr16) begin
        o_disp_len = 3'd2;
      end
    end
  end

  // Out-of-range immediate lengths saturate to a full dword.
  always_comb begin
    o_imm_bytes = 3'd0;
    if (form_has_imm(i_opnd_form)) begin
      unique case (i_imm_len)
        3'd1:    o_imm_bytes = 3'd1;
        3'd2:    o_imm_bytes = 3'd2;
        default: o_imm_bytes = 3'd4;
      endcase
    end
  end

endmodule

// File: rtl/encode_opnd_bytes.sv
// Serialising x86 instruction encoder: parallel fields in, little-endian byte stream out.
// Optional ENCODE_ADDR16_EN enables the 16-bit addressing SIB/displacement rules.
module encode_opnd_bytes
  import encode_opnd_bytes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] opcode,
  input  logic        opcode_2byte,
  input  logic [3:0]  opnd_form,
  input  logic [7:0]  modrm,
  input  logic [7:0]  sib,
  input  logic [31:0] disp,
  input  logic [31:0] imm,
  input  logic [2:0]  imm_len,
  input  logic        prefix_address_16bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [3:0]  instr_len
);

  logic       w_addr16;
  logic       w_has_modrm, w_has_sib;
  logic [2:0] w_disp_len, w_imm_bytes;
  logic [3:0] w_len;

`ifdef ENCODE_ADDR16_EN
  assign w_addr16 = prefix_address_16bit;
`else
  assign w_addr16 = 1'b0 & prefix_address_16bit;
`endif

  encode_opnd_len u_len (
    .i_opnd_form (opnd_form),
    .i_modrm     (modrm),
    .i_imm_len   (imm_len),
    .i_addr16    (w_addr16),
    .o_has_modrm (w_has_modrm),
    .o_has_sib   (w_has_sib),
    .o_disp_len  (w_disp_len),
    .o_imm_bytes (w_imm_bytes)
  );

  assign w_len = 4'd1 + {3'd0, opcode_2byte} + {3'd0, w_has_modrm} + {3'd0, w_has_sib}
               + {1'b0, w_disp_len} + {1'b0, w_imm_bytes};

  state_e      r_state;
  logic [1:0]  r_idx;
  logic [3:0]  r_pos;
  logic [15:0] r_opcode;
  logic        r_opc2, r_has_modrm, r_has_sib;
  logic [7:0]  r_modrm, r_sib;
  logic [31:0] r_disp, r_imm;
  logic [2:0]  r_disp_len, r_imm_bytes;
  logic        r_out_valid, r_out_last;
  logic [7:0]  r_out_byte;
  logic [3:0]  r_instr_len;

  state_e      w_nxt_state;
  logic [1:0]  w_nxt_idx;
  logic [7:0]  w_nxt_byte;

  // Next byte position; absent segments fall through so no bubble is inserted.
  always_comb begin
    w_nxt_state = StIdle;
    w_nxt_idx   = 2'd0;
    case (r_state)
      StOpc: begin
        if (r_idx == 2'd0 && r_opc2) begin
          w_nxt_state = StOpc;
          w_nxt_idx   = 2'd1;
        end else if (r_has_modrm)         w_nxt_state = StModrm;
        else if (r_disp_len != 3'd0)      w_nxt_state = StDisp;
        else if (r_imm_bytes != 3'd0)     w_nxt_state = StImm;
      end
      StModrm: begin
        if (r_has_sib)                    w_nxt_state = StSib;
        else if (r_disp_len != 3'd0)      w_nxt_state = StDisp;
        else if (r_imm_bytes != 3'd0)     w_nxt_state = StImm;
      end
      StSib: begin
        if (r_disp_len != 3'd0)           w_nxt_state = StDisp;
        else if (r_imm_bytes != 3'd0)     w_nxt_state = StImm;
      end
      StDisp: begin
        if (({1'b0, r_idx} + 3'd1) < r_disp_len) begin
          w_nxt_state = StDisp;
          w_nxt_idx   = r_idx + 2'd1;
        end else if (r_imm_bytes != 3'd0) w_nxt_state = StImm;
      end
      StImm: begin
        if (({1'b0, r_idx} + 3'd1) < r_imm_bytes) begin
          w_nxt_state = StImm;
          w_nxt_idx   = r_idx + 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nxt_byte = 8'h00;
    case (w_nxt_state)
      StOpc:   w_nxt_byte = w_nxt_idx[0] ? r_opcode[15:8] : r_opcode[7:0];
      StModrm: w_nxt_byte = r_modrm;
      StSib:   w_nxt_byte = r_sib;
      StDisp:  w_nxt_byte = r_disp[{w_nxt_idx, 3'b000} +: 8];
      StImm:   w_nxt_byte = r_imm[{w_nxt_idx, 3'b000} +: 8];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_idx       <= 2'd0;
      r_pos       <= 4'd0;
      r_opcode    <= 16'h0000;
      r_opc2      <= 1'b0;
      r_has_modrm <= 1'b0;
      r_has_sib   <= 1'b0;
      r_modrm     <= 8'h00;
      r_sib       <= 8'h00;
      r_disp      <= 32'h0;
      r_imm       <= 32'h0;
      r_disp_len  <= 3'd0;
      r_imm_bytes <= 3'd0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_out_last  <= 1'b0;
      r_instr_len <= 4'd0;
    end else if (r_state == StIdle) begin
      if (in_valid) begin
        r_state     <= StOpc;
        r_idx       <= 2'd0;
        r_pos       <= 4'd0;
        r_opcode    <= opcode;
        r_opc2      <= opcode_2byte;
        r_has_modrm <= w_has_modrm;
        r_has_sib   <= w_has_sib;
        r_modrm     <= modrm;
        r_sib       <= sib;
        r_disp      <= disp;
        r_imm       <= imm;
        r_disp_len  <= w_disp_len;
        r_imm_bytes <= w_imm_bytes;
        r_out_valid <= 1'b1;
        r_out_byte  <= opcode[7:0];
        r_out_last  <= (w_len == 4'd1);
        r_instr_len <= w_len;
      end
    end else if (r_out_valid && out_ready) begin
      if (r_out_last) begin
        r_state     <= StIdle;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        r_state    <= w_nxt_state;
        r_idx      <= w_nxt_idx;
        r_pos      <= r_pos + 4'd1;
        r_out_byte <= w_nxt_byte;
        r_out_last <= ((r_pos + 4'd2) == r_instr_len);
      end
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;
  assign instr_len = r_instr_len;

endmodule
